// File: rtl/uart_tx_fifo_param.sv
// FIFO-fed UART transmitter: one CLK_Baudin cycle per bit, optional parity, 1 or 2 stop bits.
// Define UART_TX_RETRY_EN to enable NACK-driven retransmission via Flag_in and the ErrTx pulse.
module uart_tx_fifo_param #(
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int MAX_RETRY   = 3
) (
    input  logic                        CLK_Baudin,
    input  logic                        RstTx,
    input  logic [DATA_W-1:0]           DataIn,
    input  logic                        NewData,
    input  logic                        Flag_in,
    output logic                        Ready,
    output logic                        TransmittedSerialData,
    output logic                        DoneTx,
    output logic                        ErrTx,
    output logic                        Busy,
    output logic [$clog2(FIFO_DEPTH):0] FifoCount
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam bit PAR_EN = (PARITY_MODE == 1) || (PARITY_MODE == 2);
    localparam bit LAST_STOP = (STOP_BITS == 2);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              push, pop;
    logic [DATA_W-1:0] head_word, next_word;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              line_q, line_d;
    logic              done_q, done_d;
`ifdef UART_TX_RETRY_EN
    logic [3:0]        retry_q, retry_d;
    logic              err_q, err_d;
`endif

    function automatic logic par_of(input logic [DATA_W-1:0] w);
        return (PARITY_MODE == 2) ? ~^w : ^w;
    endfunction

    assign Ready     = (count_q < (PTR_W+1)'(FIFO_DEPTH));
    assign push      = NewData && Ready;
    assign head_word = mem_q[rd_ptr_q];
    assign next_word = mem_q[rd_ptr_q + PTR_W'(1)];

    // Storage has no reset; pointers and count define validity.
    always_ff @(posedge CLK_Baudin) begin
        if (push) begin
            mem_q[wr_ptr_q] <= DataIn;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        line_d     = line_q;
        done_d     = 1'b0;
        pop        = 1'b0;
`ifdef UART_TX_RETRY_EN
        retry_d    = retry_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                line_d = 1'b1;
                if (count_q != '0) begin
                    shift_d = head_word;
                    par_d   = par_of(head_word);
                    line_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                line_d    = shift_q[0];
                shift_d   = shift_q >> 1;
                bit_cnt_d = '0;
                state_d   = S_DATA;
            end
            S_DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    stop_cnt_d = 1'b0;
                    line_d     = PAR_EN ? par_q : 1'b1;
                    state_d    = PAR_EN ? S_PARITY : S_STOP;
                end else begin
                    line_d    = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                line_d     = 1'b1;
                stop_cnt_d = 1'b0;
                state_d    = S_STOP;
            end
            S_STOP: begin
                if (stop_cnt_q != LAST_STOP) begin
                    stop_cnt_d = 1'b1;
                    line_d     = 1'b1;
                end else begin
`ifdef UART_TX_RETRY_EN
                    if (Flag_in && (retry_q < 4'(MAX_RETRY))) begin
                        retry_d = retry_q + 4'd1;
                    end else begin
                        pop     = 1'b1;
                        retry_d = 4'd0;
                        err_d   = Flag_in;
                        done_d  = !Flag_in;
                    end
`else
                    pop    = 1'b1;
                    done_d = 1'b1;
`endif
                    // Chain straight into the next start bit when there is more to send.
                    if (!pop) begin
                        shift_d = head_word;
                        par_d   = par_of(head_word);
                        line_d  = 1'b0;
                        state_d = S_START;
                    end else if (count_q > (PTR_W+1)'(1)) begin
                        shift_d = next_word;
                        par_d   = par_of(next_word);
                        line_d  = 1'b0;
                        state_d = S_START;
                    end else begin
                        line_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                line_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_Baudin or posedge RstTx) begin
        if (RstTx) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            line_q     <= 1'b1;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef UART_TX_RETRY_EN
            retry_q    <= 4'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            line_q     <= line_d;
            done_q     <= done_d;
`ifdef UART_TX_RETRY_EN
            retry_q    <= retry_d;
            err_q      <= err_d;
`endif
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign TransmittedSerialData = line_q;
    assign DoneTx                = done_q;
    assign Busy                  = (state_q != S_IDLE);
    assign FifoCount             = count_q;
`ifdef UART_TX_RETRY_EN
    assign ErrTx = err_q;
`else
    assign ErrTx = 1'b0;
    logic unused_flag;
    assign unused_flag = Flag_in;
    localparam int UNUSED_MAX_RETRY = MAX_RETRY;
`endif
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Scoreboard bench for uart_tx_fifo_param: expected frames/pulses are queued by the
// stimulus and consumed by per-DUT line monitors. Second instance covers odd parity, 2 stops.
module tb_uart_tx_fifo_param;
    logic       clk;
    logic       RstTx;
    logic [7:0] din1, din2;
    logic       nd1, nd2, flag1;
    logic       rdy1, line1, done1, err1, busy1;
    logic       rdy2, line2, done2, err2, busy2;
    logic [2:0] cnt1, cnt2;

    uart_tx_fifo_param #(.DATA_W(8), .FIFO_DEPTH(4), .PARITY_MODE(1), .STOP_BITS(1), .MAX_RETRY(2)) dut (
        .CLK_Baudin(clk), .RstTx(RstTx), .DataIn(din1), .NewData(nd1), .Flag_in(flag1),
        .Ready(rdy1), .TransmittedSerialData(line1), .DoneTx(done1), .ErrTx(err1),
        .Busy(busy1), .FifoCount(cnt1));

    uart_tx_fifo_param #(.DATA_W(8), .FIFO_DEPTH(4), .PARITY_MODE(2), .STOP_BITS(2), .MAX_RETRY(2)) dut2 (
        .CLK_Baudin(clk), .RstTx(RstTx), .DataIn(din2), .NewData(nd2), .Flag_in(1'b0),
        .Ready(rdy2), .TransmittedSerialData(line2), .DoneTx(done2), .ErrTx(err2),
        .Busy(busy2), .FifoCount(cnt2));

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp2_q[$];
    logic [1:0]  ev_q[$];   // {ErrTx,DoneTx}
    logic [1:0]  ev2_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Spec-level frame model for even parity, one stop bit; bit i = i-th bit period.
    function automatic logic [15:0] frame_even(input logic [7:0] w);
        return {5'b0, 1'b1, ^w, w, 1'b0};
    endfunction

    // Monitor for dut: 11-bit frames.
    initial begin
        logic in_fr;
        logic pend;
        int idx;
        logic [15:0] cap;
        logic [1:0] e;
        in_fr = 1'b0;
        pend = 1'b0;
        idx = 0;
        cap = '0;
        forever begin
            @(negedge clk);
            if (RstTx) begin
                in_fr = 1'b0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("pulse_after_frame", {31'b0, done1 | err1}, 32'd1);
                    pend = 1'b0;
                end
                if (done1 || err1) begin
                    if (ev_q.size() == 0) chk("unexpected_pulse", {30'b0, err1, done1}, 32'd0);
                    else begin
                        e = ev_q.pop_front();
                        chk("pulse_kind", {30'b0, err1, done1}, {30'b0, e});
                    end
                end
                if (!in_fr) begin
                    if (!line1) begin
                        in_fr = 1'b1;
                        cap = '0;
                        idx = 1;
                    end
                end else begin
                    cap[idx] = line1;
                    idx++;
                    if (idx == 11) begin
                        in_fr = 1'b0;
                        pend = 1'b1;
                        if (exp_q.size() == 0) chk("unexpected_frame", {16'b0, cap}, 32'hFFFF_FFFF);
                        else chk("frame", {16'b0, cap}, {16'b0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // Monitor for dut2: 12-bit frames.
    initial begin
        logic in_fr;
        logic pend;
        int idx;
        logic [15:0] cap;
        logic [1:0] e;
        in_fr = 1'b0;
        pend = 1'b0;
        idx = 0;
        cap = '0;
        forever begin
            @(negedge clk);
            if (RstTx) begin
                in_fr = 1'b0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("pulse_after_frame2", {31'b0, done2 | err2}, 32'd1);
                    pend = 1'b0;
                end
                if (done2 || err2) begin
                    if (ev2_q.size() == 0) chk("unexpected_pulse2", {30'b0, err2, done2}, 32'd0);
                    else begin
                        e = ev2_q.pop_front();
                        chk("pulse_kind2", {30'b0, err2, done2}, {30'b0, e});
                    end
                end
                if (!in_fr) begin
                    if (!line2) begin
                        in_fr = 1'b1;
                        cap = '0;
                        idx = 1;
                    end
                end else begin
                    cap[idx] = line2;
                    idx++;
                    if (idx == 12) begin
                        in_fr = 1'b0;
                        pend = 1'b1;
                        if (exp2_q.size() == 0) chk("unexpected_frame2", {16'b0, cap}, 32'hFFFF_FFFF);
                        else chk("frame2", {16'b0, cap}, {16'b0, exp2_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic push1(input logic [7:0] w);
        din1 = w;
        nd1 = 1'b1;
        @(posedge clk);
        #1;
        nd1 = 1'b0;
        $display("push dut 0x%02h", w);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || ev_q.size() != 0 || exp2_q.size() != 0 ||
                ev2_q.size() != 0 || busy1 || busy2) && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_drain"}, exp_q.size() + ev_q.size() + exp2_q.size() + ev2_q.size(), 0);
        chk({name, "_count0"}, {29'b0, cnt1}, 32'd0);
        $display("%s done after %0d cycles", name, t);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idle;
        RstTx = 1'b1;
        din1 = '0;
        din2 = '0;
        nd1 = 1'b0;
        nd2 = 1'b0;
        flag1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_line", {31'b0, line1}, 32'd1);
        chk("rst_ready", {31'b0, rdy1}, 32'd1);
        chk("rst_count", {29'b0, cnt1}, 32'd0);
        chk("rst_busy", {31'b0, busy1}, 32'd0);
        chk("rst_pulses", {30'b0, err1, done1}, 32'd0);
        RstTx = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: reset in the middle of a frame
        push1(8'h3C);
        repeat (5) @(posedge clk);
        #2 RstTx = 1'b1;
        #1;
        chk("midrst_line", {31'b0, line1}, 32'd1);
        chk("midrst_count", {29'b0, cnt1}, 32'd0);
        chk("midrst_ready", {31'b0, rdy1}, 32'd1);
        chk("midrst_busy", {31'b0, busy1}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_done", {31'b0, done1}, 32'd0);
        RstTx = 1'b0;
        $display("mid-frame reset applied");
        repeat (15) @(negedge clk);
        chk("midrst_quiet", {30'b0, busy1, done1}, 32'd0);
        @(posedge clk);
        #1;

        // Test 2: 0xA5 even parity, latency and DataIn isolation
        exp_q.push_back(16'b00000_1_0_10100101_0);
        ev_q.push_back(2'b01);
        push1(8'hA5);
        din1 = 8'hFF;
        @(negedge clk);
        chk("lat_line_hi", {31'b0, line1}, 32'd1);
        chk("lat_count1", {29'b0, cnt1}, 32'd1);
        @(negedge clk);
        chk("lat_line_lo", {31'b0, line1}, 32'd0);
        chk("lat_busy", {31'b0, busy1}, 32'd1);
        wait_idle("t2_a5");

        // Test 3: odd parity, two stop bits on dut2
        exp2_q.push_back(16'b0000_1_1_0_00000001_0);
        ev2_q.push_back(2'b01);
        din2 = 8'h01;
        nd2 = 1'b1;
        @(posedge clk);
        #1;
        nd2 = 1'b0;
        $display("push dut2 0x01");
        wait_idle("t3_odd2stop");

        // Test 4: fill FIFO, overflow push dropped, back-to-back frames
        exp_q.push_back(frame_even(8'h00));
        exp_q.push_back(frame_even(8'hFF));
        exp_q.push_back(frame_even(8'h81));
        exp_q.push_back(frame_even(8'h07));
        repeat (4) ev_q.push_back(2'b01);
        push1(8'h00);
        push1(8'hFF);
        push1(8'h81);
        push1(8'h07);
        chk("full_ready", {31'b0, rdy1}, 32'd0);
        chk("full_count", {29'b0, cnt1}, 32'd4);
        push1(8'h55);
        idle = 0;
        for (int i = 0; i < 39; i++) begin
            @(negedge clk);
            if (!busy1) idle++;
        end
        chk("no_idle_gap", idle, 0);
        wait_idle("t4_full");

        // Test 5: NACK twice then ACK
`ifdef UART_TX_RETRY_EN
        repeat (3) exp_q.push_back(frame_even(8'h3C));
`else
        exp_q.push_back(frame_even(8'h3C));
`endif
        ev_q.push_back(2'b01);
        flag1 = 1'b1;
        push1(8'h3C);
        repeat (23) @(posedge clk);
        #1 flag1 = 1'b0;
        wait_idle("t5_retry_ok");

        // Test 6: NACK on every frame end until retries are exhausted
`ifdef UART_TX_RETRY_EN
        repeat (3) exp_q.push_back(frame_even(8'hC3));
        ev_q.push_back(2'b10);
`else
        exp_q.push_back(frame_even(8'hC3));
        ev_q.push_back(2'b01);
`endif
        flag1 = 1'b1;
        push1(8'hC3);
        repeat (34) @(posedge clk);
        #1 flag1 = 1'b0;
        wait_idle("t6_retry_exhaust");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
